shape_processor_apb_bridge: RTL
===============================

# shape_processor_apb_bridge

APB3 slave front-end sitting directly upstream of `shape_processor`. It converts APB transfers into the single-cycle `write`/`read` strobes that `shape_processor` consumes. It returns the `read_data`/`error` response as `PRDATA`/`PSLVERR`. Address decode, wait-state generation and the protocol state machine live here, so `shape_processor` only ever sees one-cycle, well-formed register accesses.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: width of `paddr`.
- `CTRL_ADDR`, 'h000: byte address of the CTRL SFR; the only decoded address.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `psel`  in  1  APB select.
- `penable`  in  1  APB enable.
- `pwrite`  in  1  APB direction; 1 means write.
- `paddr`  in  ADDR_WIDTH  APB byte address.
- `pwdata`  in  32  APB write data.
- `pready`  out  1  APB ready; registered.
- `prdata`  out  32  APB read data; registered.
- `pslverr`  out  1  APB error; registered.
- `write`  out  1  write strobe to `shape_processor`; registered, one cycle wide.
- `write_data`  out  32  data accompanying `write`.
- `read`  out  1  read strobe to `shape_processor`; registered, one cycle wide.
- `read_data`  in  32  `shape_processor` read data, valid in the cycle `read` is high.
- `error`  in  1  `shape_processor` error flag, valid in the cycle `write` or `read` is high.

## Operation
The FSM has three states: IDLE, ISSUE and RESP.

- **IDLE**
  - On `psel && !penable` (setup phase), capture `pwrite`, `paddr` and `pwdata`, then go to ISSUE.
  - `penable` without a preceding setup is ignored.
- **ISSUE** (first access cycle)
  - If the captured address equals `CTRL_ADDR`: `write` (if pwrite) or `read` is high for exactly this cycle, and `write_data` equals the captured `pwdata`. In the same cycle, sample `error` into the `pslverr` register, and on reads sample `read_data` into the `prdata` register. Then go to RESP.
  - If the address does not match: no strobe is issued, the `pslverr` register is set to 1 and `prdata` to 0. Then go to RESP.
- **RESP**
  - `pready` is 1 for one cycle, with `pslverr` and `prdata` as registered. Return to IDLE.
  - `prdata` is forced to 0 on write transfers.
- **Abort:** if `psel` drops while in ISSUE or RESP, go to IDLE next cycle and clear `pready`. A strobe already issued is not retracted.
- `write_data` holds its last value when `write` is low. It is not a qualifier.
- `write` and `read` are never high in the same cycle.
- Back-to-back transfers are allowed: a setup phase seen in the RESP cycle's successor (IDLE) is accepted normally.

## Timing
- **Reset values:** `pready`=0, `pslverr`=0, `prdata`=0, `write`=0, `read`=0, `write_data`=0; state IDLE.
- **Reset asserted mid-transfer:** all outputs clear immediately (asynchronously) and the transfer is dropped. The master must re-issue it.
- **Latency:** setup cycle at N, strobe at N+1, `pready`=1 at N+2. Every transfer has exactly one wait state.
- **Throughput:** at most one transfer per 3 cycles.

## Configuration
- `SHAPE_BRIDGE_SHAPE_CHECK_EN`
  - Defined: on a write to `CTRL_ADDR`, the bridge checks `pwdata[17:16]` (SHAPE). Values 'b00 and 'b11 are illegal. For an illegal value, no `write` strobe is issued and `pslverr` is 1 in RESP, so an illegal SHAPE never reaches `shape_processor`.
  - Undefined: all writes to `CTRL_ADDR` are forwarded, and `pslverr` reflects `error` from `shape_processor`.

## Structure
- A shared package `shape_processor_pkg` holds:
  - the `ctrl_sfr_reg` packed struct (reserved1[31:18], SHAPE[17:16], reserved0[15:5], OPERATION[4:0]);
  - the `shape_e` enum (RECTANGLE='b01, TRIANGLE='b10);
  - the `is_legal_shape` function;
  - the bridge FSM state enum.
- No sub-module; a single module.

## Test plan
- **Legal write:** APB write to 'h000 with `pwdata`='h0001_0003 → `write`=1 for one cycle with `write_data`='h0001_0003, then `pready`=1 two cycles after setup with `pslverr`=0.
- **Read:** APB read from 'h000 with `read_data`='h0002_0007 driven during the `read` cycle → `prdata`='h0002_0007, `pslverr`=0 in the `pready` cycle.
- **Unmapped address:** APB write to 'h004 → no `write` strobe; `pready`=1 with `pslverr`=1; a read from 'h004 returns `prdata`=0 with `pslverr`=1.
- **Illegal SHAPE:** write with `pwdata`='h0003_0001.
  - With the macro defined: no strobe, `pslverr`=1.
  - Without it: strobe issued, and `pslverr` equals `error` from `shape_processor`.
- **Reset mid-transfer:** `rst_n`=0 in the ISSUE cycle → `write`, `read`, `pready`, `pslverr` and `prdata` are 0 immediately. After release, a new transfer completes in 3 cycles.
- **Abort and back-to-back:** dropping `psel` in ISSUE → FSM returns to IDLE with no `pready`. Two consecutive writes → strobes 3 cycles apart, each with its own `pready` pulse.

Source files
------------

// File: rtl/shape_processor_pkg.sv
// Shared types for shape_processor and its APB bridge: CTRL SFR layout,
// SHAPE encodings, the legality helper and the bridge FSM states.
package shape_processor_pkg;

   typedef struct packed {
      logic [13:0] reserved1;
      logic [1:0]  shape;
      logic [10:0] reserved0;
      logic [4:0]  operation;
   } ctrl_sfr_reg;

   typedef enum logic [1:0] {
      RECTANGLE = 2'b01,
      TRIANGLE  = 2'b10
   } shape_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } bridge_state_e;

   localparam int SHAPE_LSB = 16;

   function automatic logic is_legal_shape(input logic [1:0] shape);
      return (shape == RECTANGLE) || (shape == TRIANGLE);
   endfunction

endpackage

// File: rtl/shape_processor_apb_bridge.sv
// APB3 slave that turns each transfer into one registered write/read strobe to
// shape_processor. Optional SHAPE screening on CTRL writes: SHAPE_BRIDGE_SHAPE_CHECK_EN.
module shape_processor_apb_bridge
   import shape_processor_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 12,
   parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR  = 'h000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [31:0]           pwdata,
   output logic                  pready,
   output logic [31:0]           prdata,
   output logic                  pslverr,
   output logic                  write,
   output logic [31:0]           write_data,
   output logic                  read,
   input  logic [31:0]           read_data,
   input  logic                  error,
   output logic [1:0]            dbg_state
);

   // Handshake: a transfer is accepted on psel && !penable in IDLE; the
   // strobe fires the next cycle, and pready completes it one cycle later.
   // Dropping psel before completion abandons the transfer without pready.

   bridge_state_e state_q, state_d;
   logic          pwrite_q, pwrite_d;
   logic          hit_q, hit_d;
   logic          shape_ok_q, shape_ok_d;
   logic          write_q, write_d;
   logic          read_q, read_d;
   logic [31:0]   write_data_q, write_data_d;
   logic          pready_q, pready_d;
   logic          pslverr_q, pslverr_d;
   logic [31:0]   prdata_q, prdata_d;

   logic          setup;
   logic          addr_hit;
   logic          shape_ok_in;

   assign setup    = psel && !penable;
   assign addr_hit = (paddr == CTRL_ADDR);

`ifdef SHAPE_BRIDGE_SHAPE_CHECK_EN
   assign shape_ok_in = is_legal_shape(pwdata[SHAPE_LSB+1:SHAPE_LSB]);
`else
   assign shape_ok_in = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      pwrite_d     = pwrite_q;
      hit_d        = hit_q;
      shape_ok_d   = shape_ok_q;
      write_d      = 1'b0;
      read_d       = 1'b0;
      write_data_d = write_data_q;
      pready_d     = 1'b0;
      pslverr_d    = 1'b0;
      prdata_d     = 32'h0;

      case (state_q)
         ST_IDLE: begin
            if (setup) begin
               state_d    = ST_ISSUE;
               pwrite_d   = pwrite;
               hit_d      = addr_hit;
               shape_ok_d = shape_ok_in;
               // Strobes are decided here so they are flop outputs in ISSUE.
               if (addr_hit) begin
                  if (pwrite && shape_ok_in) begin
                     write_d      = 1'b1;
                     write_data_d = pwdata;
                  end else if (!pwrite) begin
                     read_d = 1'b1;
                  end
               end
            end
         end
         ST_ISSUE: begin
            if (!psel) begin
               state_d = ST_IDLE;
            end else begin
               state_d  = ST_RESP;
               pready_d = 1'b1;
               if (hit_q && (!pwrite_q || shape_ok_q)) begin
                  pslverr_d = error;
                  prdata_d  = pwrite_q ? 32'h0 : read_data;
               end else begin
                  pslverr_d = 1'b1;
               end
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pwrite_q     <= 1'b0;
         hit_q        <= 1'b0;
         shape_ok_q   <= 1'b0;
         write_q      <= 1'b0;
         read_q       <= 1'b0;
         write_data_q <= 32'h0;
         pready_q     <= 1'b0;
         pslverr_q    <= 1'b0;
         prdata_q     <= 32'h0;
      end else begin
         state_q      <= state_d;
         pwrite_q     <= pwrite_d;
         hit_q        <= hit_d;
         shape_ok_q   <= shape_ok_d;
         write_q      <= write_d;
         read_q       <= read_d;
         write_data_q <= write_data_d;
         pready_q     <= pready_d;
         pslverr_q    <= pslverr_d;
         prdata_q     <= prdata_d;
      end
   end

   assign pready     = pready_q;
   assign prdata     = prdata_q;
   assign pslverr    = pslverr_q;
   assign write      = write_q;
   assign read       = read_q;
   assign write_data = write_data_q;
   assign dbg_state  = state_q;

endmodule
